aes_block_assembler: RTL and testbench
======================================

// Module: aes_block_assembler
// PURPOSE
// - Input stage directly upstream of the AES engine.
// - Collects DATA_W-bit words from the streamer source into BLOCK_W-bit AES blocks.
// - Hands each block to the engine over a valid/ready handshake.
// - Double-buffered: one block is assembled while the previous one waits for the engine.
// - Programmed by the HWPE controller with a block count; reports busy/done and progress.
// PARAMETERS
// - DATA_W    32   width of an input stream word
// - BLOCK_W   128  AES block width; must be an integer multiple of DATA_W
// - CNT_W     16   width of the block-count register and counters
// - NW        BLOCK_W/DATA_W (localparam)  words per block, 4 at defaults
// PORTS
// - clk_i        in   1        single clock
// - rst_i        in   1        synchronous reset, active-high
// - start_i      in   1        one-cycle pulse: begin a job (honoured only in IDLE)
// - clear_i      in   1        synchronous abort: flush both buffers, return to IDLE
// - nb_blocks_i  in   CNT_W    number of blocks in the job, sampled on start_i
// - swap_i       in   1        1: byte-reverse each word on capture; sampled on start_i
// - in_data_i    in   DATA_W   input word
// - in_valid_i   in   1        input word valid
// - in_ready_o   out  1        assembler can accept a word
// - out_data_o   out  BLOCK_W  assembled block to the engine
// - out_valid_o  out  1        block valid
// - out_ready_i  in   1        engine accepts the block
// - busy_o       out  1        high in RUN
// - done_o       out  1        one-cycle pulse when the last block is accepted by the engine
// - blk_cnt_o    out  CNT_W    blocks handed to the engine in the current job
// BEHAVIOUR
// - Reset (rst_i=1 at a clk_i edge):
//   - FSM goes to IDLE; counters and buffers are cleared.
//   - in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, blk_cnt_o=0.
//   - A reset mid-job discards all partial and pending data.
// - FSM states IDLE, RUN, DONE:
//   - IDLE --start_i--> RUN. The job registers latch nb_blocks_i and swap_i, and blk_cnt_o clears.
//   - In IDLE, start_i with nb_blocks_i=0 goes to DONE instead. No handshakes occur.
//   - RUN --(last block accepted: out_valid_o & out_ready_i & blk_cnt+1==nb)--> DONE.
//   - DONE --> IDLE unconditionally. done_o=1 only in DONE, so it is exactly one cycle.
//   - start_i is ignored outside IDLE.
//   - clear_i from any state goes to IDLE next cycle: buffers are emptied and out_valid_o drops.
//     blk_cnt_o holds its value, and done_o is not pulsed.
//   - When clear_i and start_i arrive in the same cycle, clear_i wins.
// - Input handshake: a word transfers when in_valid_i & in_ready_o.
//   - in_ready_o = RUN & (words_accepted < nb*NW) & !(assembly full & output buffer full).
//   - in_ready_o does not depend combinationally on in_valid_i.
// - Packing:
//   - Word k of a block (k=0..NW-1, arrival order) is written to bits [DATA_W*k +: DATA_W].
//   - With swap set, the word is byte-reversed before it is written.
//   - A 2-bit word index counts 0..NW-1 and wraps to 0 when the block completes.
// - Output buffer:
//   - The completed assembly register moves to the output register on the cycle after the last word.
//   - Latency: last word accepted at edge t gives out_valid_o=1 from edge t+1 (registered).
//   - out_data_o and out_valid_o are stable while out_valid_o & !out_ready_i.
//   - If the output register is being emptied (out_ready_i=1) in the same cycle a block completes,
//     the new block loads with no bubble.
//   - If the output register is full and not emptied, the completed block stays in the assembly register.
//     in_ready_o drops until the transfer frees space.
// - Throughput: sustained one word/cycle, one block per NW cycles, with out_ready_i held at 1.
// - Counters: blk_cnt_o increments on each output handshake and saturates at nb.
//   The word counter is CNT_W+$clog2(NW) bits wide, so no overflow occurs.
// - Words offered after the job quota are not accepted (in_ready_o=0).
// STRUCTURE
// - aes_package gets:
//   - assembler_ctrl_t {start, clear, nb_blocks, swap}
//   - assembler_flags_t {busy, done, blk_cnt}
//   - state enum asm_state_e
//   - constant AES_BLOCK_W=128
// - One sub-module: aes_block_buf.
//   - A single-entry BLOCK_W register with valid/ready (a pipeline register) that forms the output buffer.
//   - The FSM, counters, byte swap and assembly register stay in the top.
// TESTING
// - nb=2, swap=0, words 0x00000001..0x00000008 back-to-back, out_ready=1:
//   - blocks 0x00000004_00000003_00000002_00000001 and 0x...08_07_06_05 appear.
//   - out_valid comes 1 cycle after each 4th word.
//   - done pulses once, and blk_cnt_o=2.
// - swap=1, one word 0x11223344 per block position, nb=1:
//   - each 32-bit lane of the block reads 0x44332211.
// - nb=3, out_ready=0 for 20 cycles then 1:
//   - exactly 8 words are accepted and in_ready_o=0 afterwards.
//   - after release, all 3 blocks drain in order with out_data stable while stalled.
// - nb=0 start:
//   - done pulses on the next cycle and in_ready_o stays 0.
// - nb=4; clear_i after 6 words, then start nb=1:
//   - out_valid drops and no stale data is emitted.
//   - the new block contains only post-restart words.
// - rst_i asserted mid-block with 2 words pending:
//   - all outputs return to their reset values on the next edge.
//   - the first block after restart is built from fresh words only.

Source files
------------

// File: rtl/aes_block_assembler_pkg.sv
// Shared types and constants for the AES block assembler: FSM state encoding,
// control/flag bundles exchanged with the HWPE controller.
package aes_block_assembler_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int ASM_CNT_W   = 16;

  typedef enum logic [1:0] {
    ASM_IDLE = 2'd0,
    ASM_RUN  = 2'd1,
    ASM_DONE = 2'd2
  } asm_state_e;

  typedef struct packed {
    logic                 start;
    logic                 clear;
    logic [ASM_CNT_W-1:0] nb_blocks;
    logic                 swap;
  } assembler_ctrl_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [ASM_CNT_W-1:0] blk_cnt;
  } assembler_flags_t;

endpackage

// File: rtl/aes_block_buf.sv
// Single-entry pipeline register with valid/ready on both sides; it can be
// refilled in the same cycle it is drained, so a full stream sees no bubbles.
module aes_block_buf
  import aes_block_assembler_pkg::*;
#(
  parameter int W = AES_BLOCK_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_q  <= in_data;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_block_assembler.sv
// Packs DATA_W-bit stream words into BLOCK_W-bit AES blocks and hands them to
// the engine through a one-entry output buffer (double-buffered with the assembly register).
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high; valid never waits on ready, and in_ready_o / out_valid_o never
// depend combinationally on in_valid_i.
module aes_block_assembler
  import aes_block_assembler_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = ASM_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [CNT_W-1:0]   nb_blocks_i,
  input  logic               swap_i,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BLOCK_W-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   blk_cnt_o,
  output logic [1:0]         state_o
);

  localparam int NW    = BLOCK_W / DATA_W;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int WC_W  = CNT_W + IDX_W;

  asm_state_e       state_q, state_d;
  assembler_ctrl_t  ctrl;
  assembler_flags_t flags;

  logic [CNT_W-1:0]   nb_q, blk_cnt_q;
  logic               swap_q;
  logic [WC_W-1:0]    wcnt_q, quota;
  logic [IDX_W-1:0]   widx_q;
  logic [BLOCK_W-1:0] asm_q;
  logic               asm_full_q;
  logic [DATA_W-1:0]  word;
  logic               in_fire, out_fire, last_word, last_blk, buf_in_ready, move;

  assign ctrl = '{start: start_i, clear: clear_i, nb_blocks: nb_blocks_i, swap: swap_i};

  assign quota     = WC_W'(nb_q) * WC_W'(NW);
  assign in_fire   = in_valid_i && in_ready_o;
  assign out_fire  = out_valid_o && out_ready_i;
  assign last_word = (widx_q == IDX_W'(NW - 1));
  assign last_blk  = ((blk_cnt_q + CNT_W'(1)) == nb_q);
  assign move      = asm_full_q && buf_in_ready;

  always_comb begin
    word = in_data_i;
    if (swap_q) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        word[8*b +: 8] = in_data_i[DATA_W-8-8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ASM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ctrl.clear) begin
      state_d = ASM_IDLE;
    end else begin
      case (state_q)
        ASM_IDLE: if (ctrl.start) state_d = (ctrl.nb_blocks == '0) ? ASM_DONE : ASM_RUN;
        ASM_RUN:  if (out_fire && last_blk) state_d = ASM_DONE;
        ASM_DONE: state_d = ASM_IDLE;
        default:  state_d = ASM_IDLE;
      endcase
    end
  end

  // Stop taking words only when both stages hold a complete block.
  always_comb begin
    flags.busy    = (state_q == ASM_RUN);
    flags.done    = (state_q == ASM_DONE);
    flags.blk_cnt = blk_cnt_q;
    in_ready_o    = (state_q == ASM_RUN) && (wcnt_q < quota) && !(asm_full_q && out_valid_o);
  end

  assign busy_o    = flags.busy;
  assign done_o    = flags.done;
  assign blk_cnt_o = flags.blk_cnt;
  assign state_o   = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nb_q       <= '0;
      swap_q     <= 1'b0;
      blk_cnt_q  <= '0;
      wcnt_q     <= '0;
      widx_q     <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
    end else if (ctrl.clear) begin
      wcnt_q     <= '0;
      widx_q     <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
    end else if (state_q == ASM_IDLE && ctrl.start) begin
      nb_q       <= ctrl.nb_blocks;
      swap_q     <= ctrl.swap;
      blk_cnt_q  <= '0;
      wcnt_q     <= '0;
      widx_q     <= '0;
      asm_full_q <= 1'b0;
    end else begin
      if (out_fire && blk_cnt_q != nb_q) blk_cnt_q <= blk_cnt_q + CNT_W'(1);
      if (in_fire) begin
        asm_q[int'(widx_q)*DATA_W +: DATA_W] <= word;
        wcnt_q <= wcnt_q + WC_W'(1);
        widx_q <= last_word ? '0 : widx_q + IDX_W'(1);
      end
      if (in_fire && last_word) asm_full_q <= 1'b1;
      else if (move)            asm_full_q <= 1'b0;
    end
  end

  aes_block_buf #(.W(BLOCK_W)) u_out_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .in_data   (asm_q),
    .in_valid  (asm_full_q),
    .in_ready  (buf_in_ready),
    .out_data  (out_data_o),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i)
  );

endmodule

// File: tb/tb_aes_block_assembler.sv
// Directed bench for aes_block_assembler: packing, byte swap, back-pressure,
// zero-length jobs, abort and mid-job reset, with hand-computed expected blocks.
module tb_aes_block_assembler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i, clear_i, swap_i;
  logic [15:0]  nb_blocks_i;
  logic [31:0]  in_data_i;
  logic         in_valid_i, in_ready_o;
  logic [127:0] out_data_o;
  logic         out_valid_o, out_ready_i;
  logic         busy_o, done_o;
  logic [15:0]  blk_cnt_o;
  logic [1:0]   state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  aes_block_assembler dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .nb_blocks_i(nb_blocks_i), .swap_i(swap_i), .in_data_i(in_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o),
    .done_o(done_o), .blk_cnt_o(blk_cnt_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic do_start(input logic [15:0] nb, input logic sw);
    start_i = 1'b1; nb_blocks_i = nb; swap_i = sw;
    tick();
    start_i = 1'b0;
  endtask

  // Feeds words base+step*k whenever ready; every offered block is checked
  // against exp_q; ends when done_o is seen, then confirms the pulse is one cycle.
  task automatic run_job(input int bound, input logic [31:0] base, input int step, input int acc0);
    int   acc = acc0;
    bit   seen = 1'b0;
    logic took;
    for (int c = 0; c < bound && !seen; c++) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) check("extra_blk", {127'd0, out_valid_o}, 128'd0);
          else check("blk_data", out_data_o, exp_q.pop_front());
        end
        in_valid_i = 1'b1;
        in_data_i  = base + 32'(step * acc);
        took = in_ready_o;
        tick();
        if (took) acc++;
      end
    end
    in_valid_i = 1'b0;
    check("done_seen", {127'd0, seen}, 128'd1);
    check("exp_empty", 128'(exp_q.size()), 128'd0);
    tick();
    check("done_one_cycle", {127'd0, done_o}, 128'd0);
  endtask

  initial begin
    int   acc;
    logic took;
    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; swap_i = 1'b0;
    nb_blocks_i = '0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick(); tick();

    // reset values
    check("rst_in_ready", {127'd0, in_ready_o}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid_o}, 128'd0);
    check("rst_out_data", out_data_o, 128'd0);
    check("rst_busy", {127'd0, busy_o}, 128'd0);
    check("rst_done", {127'd0, done_o}, 128'd0);
    check("rst_blk_cnt", 128'(blk_cnt_o), 128'd0);
    rst_i = 1'b0;
    tick();

    // two blocks, back-to-back words 1..8, engine always ready
    do_start(16'd2, 1'b0);
    check("t1_busy", {127'd0, busy_o}, 128'd1);
    check("t1_blk_cnt0", 128'(blk_cnt_o), 128'd0);
    for (int i = 1; i <= 8; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'(i);
      check("t1_in_ready", {127'd0, in_ready_o}, 128'd1);
      tick();
      check("t1_out_valid", {127'd0, out_valid_o}, {127'd0, (i == 5)});
      if (i == 5) check("t1_blk0", out_data_o, 128'h00000004_00000003_00000002_00000001);
    end
    in_valid_i = 1'b0;
    check("t1_quota", {127'd0, in_ready_o}, 128'd0);
    tick();
    check("t1_blk1_valid", {127'd0, out_valid_o}, 128'd1);
    check("t1_blk1", out_data_o, 128'h00000008_00000007_00000006_00000005);
    check("t1_blk_cnt1", 128'(blk_cnt_o), 128'd1);
    check("t1_no_done_yet", {127'd0, done_o}, 128'd0);
    tick();
    check("t1_done", {127'd0, done_o}, 128'd1);
    check("t1_blk_cnt2", 128'(blk_cnt_o), 128'd2);
    check("t1_busy_off", {127'd0, busy_o}, 128'd0);
    tick();
    check("t1_done_gone", {127'd0, done_o}, 128'd0);
    check("t1_idle", 128'(state_o), 128'd0);

    // byte swap: every lane becomes 0x44332211
    do_start(16'd1, 1'b1);
    exp_q.push_back(128'h44332211_44332211_44332211_44332211);
    run_job(30, 32'h11223344, 0, 0);
    check("t2_blk_cnt", 128'(blk_cnt_o), 128'd1);

    // back-pressure: 8 words fit in assembly + output stages, then stall
    out_ready_i = 1'b0;
    do_start(16'd3, 1'b0);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid_i = 1'b1; in_data_i = 32'h100 + 32'(acc);
      took = in_ready_o;
      tick();
      if (took) acc++;
      if (c == 12) check("t3_stall_data_mid", out_data_o, blk(32'h100, 32'h101, 32'h102, 32'h103));
    end
    check("t3_accepted", 128'(acc), 128'd8);
    check("t3_in_ready_low", {127'd0, in_ready_o}, 128'd0);
    check("t3_stall_valid", {127'd0, out_valid_o}, 128'd1);
    check("t3_stall_data_end", out_data_o, blk(32'h100, 32'h101, 32'h102, 32'h103));
    out_ready_i = 1'b1;
    exp_q.push_back(blk(32'h100, 32'h101, 32'h102, 32'h103));
    exp_q.push_back(blk(32'h104, 32'h105, 32'h106, 32'h107));
    exp_q.push_back(blk(32'h108, 32'h109, 32'h10a, 32'h10b));
    run_job(40, 32'h100, 1, acc);
    check("t3_blk_cnt", 128'(blk_cnt_o), 128'd3);

    // zero-length job
    do_start(16'd0, 1'b0);
    check("t4_done", {127'd0, done_o}, 128'd1);
    check("t4_in_ready", {127'd0, in_ready_o}, 128'd0);
    tick();
    check("t4_done_gone", {127'd0, done_o}, 128'd0);
    check("t4_in_ready2", {127'd0, in_ready_o}, 128'd0);

    // abort after 6 words with a block parked in the output register
    out_ready_i = 1'b0;
    do_start(16'd4, 1'b0);
    acc = 0;
    for (int c = 0; c < 20 && acc < 6; c++) begin
      in_valid_i = 1'b1; in_data_i = 32'h200 + 32'(acc);
      took = in_ready_o;
      tick();
      if (took) acc++;
    end
    in_valid_i = 1'b0;
    check("t5_pending_valid", {127'd0, out_valid_o}, 128'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("t5_valid_dropped", {127'd0, out_valid_o}, 128'd0);
    check("t5_idle", 128'(state_o), 128'd0);
    check("t5_no_done", {127'd0, done_o}, 128'd0);
    check("t5_in_ready", {127'd0, in_ready_o}, 128'd0);
    out_ready_i = 1'b1;
    do_start(16'd1, 1'b0);
    exp_q.push_back(blk(32'h300, 32'h301, 32'h302, 32'h303));
    run_job(30, 32'h300, 1, 0);

    // reset in the middle of a block
    do_start(16'd2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'h500 + 32'(i);
      tick();
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    check("t6_in_ready", {127'd0, in_ready_o}, 128'd0);
    check("t6_out_valid", {127'd0, out_valid_o}, 128'd0);
    check("t6_out_data", out_data_o, 128'd0);
    check("t6_busy", {127'd0, busy_o}, 128'd0);
    check("t6_done", {127'd0, done_o}, 128'd0);
    check("t6_blk_cnt", 128'(blk_cnt_o), 128'd0);
    rst_i = 1'b0;
    tick();
    do_start(16'd1, 1'b0);
    exp_q.push_back(blk(32'h600, 32'h601, 32'h602, 32'h603));
    run_job(30, 32'h600, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
